// File: rtl/alu_seq_pkg.sv
// Shared types and control-word layout for the alu_seq_ctrl microprogram sequencer.
// Optional single-step hold in READ is enabled with ALU_SEQ_SINGLE_STEP_EN.
package alu_seq_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int CW_W          = 14;

    localparam int OPR_LSB  = 9;
    localparam int OPR_W    = 5;
    localparam int SELD_LSB = 6;
    localparam int SELA_LSB = 3;
    localparam int SELB_LSB = 0;
    localparam int SEL_W    = 3;

    // A control word that writes R0 is reserved as the HALT marker.
    localparam logic [SEL_W-1:0] HALT_SELD = '0;

    // Encoding is visible on the debug state port, so keep it fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_READ  = 3'd2,
        ST_CALC  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    function automatic logic [OPR_W-1:0] cw_opr(input logic [CW_W-1:0] cw);
        return cw[OPR_LSB +: OPR_W];
    endfunction

    function automatic logic [SEL_W-1:0] cw_seld(input logic [CW_W-1:0] cw);
        return cw[SELD_LSB +: SEL_W];
    endfunction

    function automatic logic [SEL_W-1:0] cw_sela(input logic [CW_W-1:0] cw);
        return cw[SELA_LSB +: SEL_W];
    endfunction

    function automatic logic [SEL_W-1:0] cw_selb(input logic [CW_W-1:0] cw);
        return cw[SELB_LSB +: SEL_W];
    endfunction

    function automatic logic cw_is_halt(input logic [CW_W-1:0] cw);
        return cw_seld(cw) == HALT_SELD;
    endfunction

endpackage

// File: rtl/alu_seq_store.sv
// Microprogram store: DEPTH x CW_W register array, synchronous write, combinational read.
// Contents are deliberately not reset so a loaded program survives a sequencer reset.
module alu_seq_store
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [CW_W-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [CW_W-1:0] rdata_o
);

    logic [CW_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Microprogram sequencer: steps each control word through FETCH/READ/CALC/WRITE and
// stops on a HALT word (SELD==0). ALU_SEQ_SINGLE_STEP_EN adds a step input gating READ.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PC_W  = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              load_en,
    input  logic [PC_W-1:0]   load_addr,
    input  logic [CW_W-1:0]   load_data,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic              abort,
`ifdef ALU_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [SEL_W-1:0]  SELA,
    output logic [SEL_W-1:0]  SELB,
    output logic [SEL_W-1:0]  SELD,
    output logic [OPR_W-1:0]  OPR,
    output logic              WE,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        dbg_state_o
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CW_W-1:0] ir_q, ir_d;
    logic            done_q, done_d;
    logic [CW_W-1:0] mem_rdata;
    logic            store_we;
    logic            exec;
    logic            read_go;

    // Loads are only accepted while idle so a running program cannot be patched.
    assign store_we = load_en && (state_q == ST_IDLE);

    alu_seq_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk_i   (Clock),
        .we_i    (store_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

`ifdef ALU_SEQ_SINGLE_STEP_EN
    assign read_go = step;
`else
    assign read_go = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        done_d  = 1'b0;
        if (abort) begin
            // Abort wins over every transition; PC and IR are left as they were.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pc_d    = start_pc;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir_d = mem_rdata;
                    if (cw_is_halt(mem_rdata)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (read_go) begin
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    // DEPTH is a power of two, so the natural PC_W overflow is the wrap.
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Fields are held through READ/CALC/WRITE so the ALU settles before the WE edge.
    assign exec = (state_q == ST_READ) || (state_q == ST_CALC) || (state_q == ST_WRITE);

    assign SELA        = exec ? cw_sela(ir_q) : '0;
    assign SELB        = exec ? cw_selb(ir_q) : '0;
    assign SELD        = exec ? cw_seld(ir_q) : '0;
    assign OPR         = exec ? cw_opr(ir_q)  : '0;
    assign WE          = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign pc          = pc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        Clock;
  logic        Reset_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [13:0] load_data;
  logic        start;
  logic [3:0]  start_pc;
  logic        abort;
`ifdef ALU_SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [2:0]  SELA, SELB, SELD;
  logic [4:0]  OPR;
  logic        WE, busy, done;
  logic [3:0]  pc;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  alu_seq_ctrl dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .start_pc    (start_pc),
    .abort       (abort),
`ifdef ALU_SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .SELA        (SELA),
    .SELB        (SELB),
    .SELD        (SELD),
    .OPR         (OPR),
    .WE          (WE),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // control words {OPR, SELD, SELA, SELB}
  localparam logic [13:0] W0  = {5'd0, 3'd7, 3'd0, 3'd1};
  localparam logic [13:0] H1  = {5'd3, 3'd0, 3'd2, 3'd2};
  localparam logic [13:0] HZ  = 14'd0;
  localparam logic [13:0] W15 = {5'd1, 3'd3, 3'd4, 3'd5};
  localparam logic [13:0] W2  = {5'd2, 3'd6, 3'd1, 3'd1};
  localparam logic [13:0] W7  = {5'd0, 3'd7, 3'd7, 3'd7};

  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SR = 3'd2, SC = 3'd3, SW = 3'd4;

  typedef struct {
    logic        rst_n;
    logic        ld;
    logic [3:0]  la;
    logic [13:0] ldat;
    logic        st;
    logic [3:0]  spc;
    logic        ab;
    logic [2:0]  e_state;
    logic [3:0]  e_pc;
    logic        e_busy;
    logic        e_done;
    logic        e_we;
    logic [13:0] e_cw;
  } vec_t;

  vec_t vec_q[$];

  function automatic void a(input logic rst_n, input logic ld, input logic [3:0] la,
                            input logic [13:0] ldat, input logic st, input logic [3:0] spc,
                            input logic ab, input logic [2:0] es, input logic [3:0] epc,
                            input logic eb, input logic ed, input logic ew,
                            input logic [13:0] ecw);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.la = la; v.ldat = ldat; v.st = st; v.spc = spc; v.ab = ab;
    v.e_state = es; v.e_pc = epc; v.e_busy = eb; v.e_done = ed; v.e_we = ew; v.e_cw = ecw;
    vec_q.push_back(v);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; start_pc = '0; abort = 1'b0;
  endtask

  logic [23:0] obs, exp_v;
  bit          seen_we;

  initial begin
    Reset_n = 1'b0;
    drive_idle();
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif

    // A: one word then HALT
    a(1,1,0,W0, 0,0,0, SI,0,0,0,0,0);
    a(1,1,1,H1, 0,0,0, SI,0,0,0,0,0);
    a(1,0,0,0,  1,0,0, SI,0,0,0,0,0);
    a(1,0,0,0,  0,0,0, SF,0,1,0,0,0);
    a(1,0,0,0,  0,0,0, SR,0,1,0,0,W0);
    a(1,0,0,0,  0,0,0, SC,0,1,0,0,W0);
    a(1,0,0,0,  0,0,0, SW,0,1,0,1,W0);
    a(1,0,0,0,  0,0,0, SF,1,1,0,0,0);
    a(1,0,0,0,  0,0,0, SI,1,0,1,0,0);
    a(1,0,0,0,  0,0,0, SI,1,0,0,0,0);
    // B: immediate HALT at 5
    a(1,1,5,HZ, 0,0,0, SI,1,0,0,0,0);
    a(1,0,0,0,  1,5,0, SI,1,0,0,0,0);
    a(1,0,0,0,  0,0,0, SF,5,1,0,0,0);
    a(1,0,0,0,  0,0,0, SI,5,0,1,0,0);
    a(1,0,0,0,  0,0,0, SI,5,0,0,0,0);
    // C: execute at 15, wrap to 0, HALT
    a(1,1,15,W15,0,0,0, SI,5,0,0,0,0);
    a(1,1,0,HZ,  0,0,0, SI,5,0,0,0,0);
    a(1,0,0,0,   1,15,0, SI,5,0,0,0,0);
    a(1,0,0,0,   0,0,0, SF,15,1,0,0,0);
    a(1,0,0,0,   0,0,0, SR,15,1,0,0,W15);
    a(1,0,0,0,   0,0,0, SC,15,1,0,0,W15);
    a(1,0,0,0,   0,0,0, SW,15,1,0,1,W15);
    a(1,0,0,0,   0,0,0, SF,0,1,0,0,0);
    a(1,0,0,0,   0,0,0, SI,0,0,1,0,0);
    // D: load+start same cycle; start/load ignored while busy
    a(1,1,3,HZ, 0,0,0, SI,0,0,0,0,0);
    a(1,1,2,W2, 1,2,0, SI,0,0,0,0,0);
    a(1,0,0,0,  0,0,0, SF,2,1,0,0,0);
    a(1,1,0,W7, 1,9,0, SR,2,1,0,0,W2);
    a(1,1,0,W7, 1,9,0, SC,2,1,0,0,W2);
    a(1,1,0,W7, 1,9,0, SW,2,1,0,1,W2);
    a(1,0,0,0,  0,0,0, SF,3,1,0,0,0);
    a(1,0,0,0,  0,0,0, SI,3,0,1,0,0);
    a(1,0,0,0,  1,0,0, SI,3,0,0,0,0);
    a(1,0,0,0,  0,0,0, SF,0,1,0,0,0);
    a(1,0,0,0,  0,0,0, SI,0,0,1,0,0);
    // E: abort during READ
    a(1,0,0,0,  1,2,0, SI,0,0,0,0,0);
    a(1,0,0,0,  0,0,0, SF,2,1,0,0,0);
    a(1,0,0,0,  0,0,1, SR,2,1,0,0,W2);
    a(1,0,0,0,  0,0,0, SI,2,0,0,0,0);
    a(1,0,0,0,  0,0,0, SI,2,0,0,0,0);
    // F: reset during CALC
    a(1,0,0,0,  1,2,0, SI,2,0,0,0,0);
    a(1,0,0,0,  0,0,0, SF,2,1,0,0,0);
    a(1,0,0,0,  0,0,0, SR,2,1,0,0,W2);
    a(0,0,0,0,  0,0,0, SC,2,1,0,0,W2);
    a(1,0,0,0,  0,0,0, SI,0,0,0,0,0);
    // G: abort during a HALT fetch suppresses done
    a(1,0,0,0,  1,3,0, SI,0,0,0,0,0);
    a(1,0,0,0,  0,0,1, SF,3,1,0,0,0);
    a(1,0,0,0,  0,0,0, SI,3,0,0,0,0);

    tick();
    tick();

    foreach (vec_q[i]) begin
      Reset_n   = vec_q[i].rst_n;
      load_en   = vec_q[i].ld;
      load_addr = vec_q[i].la;
      load_data = vec_q[i].ldat;
      start     = vec_q[i].st;
      start_pc  = vec_q[i].spc;
      abort     = vec_q[i].ab;
      obs   = {dbg_state, pc, busy, done, WE, OPR, SELD, SELA, SELB};
      exp_v = {vec_q[i].e_state, vec_q[i].e_pc, vec_q[i].e_busy, vec_q[i].e_done,
               vec_q[i].e_we, vec_q[i].e_cw};
      chk($sformatf("row %0d", i), 32'(obs), 32'(exp_v));
      tick();
    end
    Reset_n = 1'b1;
    drive_idle();

    // abort in WRITE: PC must not advance, WE drops
    start = 1'b1; start_pc = 4'd2;
    tick();
    start = 1'b0;
    seen_we = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (WE) begin
        seen_we = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_wr reach WE", 32'(seen_we), 32'd1);
    chk("abort_wr pc in WRITE", 32'(pc), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wr state", 32'(dbg_state), 32'(SI));
    chk("abort_wr pc held", 32'(pc), 32'd2);
    chk("abort_wr WE", 32'(WE), 32'd0);
    chk("abort_wr done", 32'(done), 32'd0);
    tick();
    chk("abort_wr done later", 32'(done), 32'd0);

`ifdef ALU_SEQ_SINGLE_STEP_EN
    // single step: hold in READ, then one step -> WE two cycles later
    step = 1'b0;
    start = 1'b1; start_pc = 4'd2;
    tick();
    start = 1'b0;
    tick();
    for (int n = 0; n < 10; n++) tick();
    chk("step hold state", 32'(dbg_state), 32'(SR));
    chk("step hold WE", 32'(WE), 32'd0);
    chk("step hold SELD", 32'(SELD), 32'd6);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step calc", 32'(dbg_state), 32'(SC));
    tick();
    chk("step WE", 32'(WE), 32'd1);
    tick();
    chk("step fetch pc", 32'(pc), 32'd3);
    tick();
    chk("step done", 32'(done), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
